// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: fetch FSM states, flush value and the
// {instruction, PC+4} record that moves from IF to ID.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WAIT_OUT = 2'd2,
    DROP     = 2'd3
  } fetch_state_t;

  // Instruction value seen on the IF/ID outputs after reset or a flush.
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
  // Address of the first fetch after reset unless overridden.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc_next;
  } fetch_entry_t;

endpackage

// File: rtl/if_skid_buf.sv
// Two-entry IF/ID output buffer: a head register that drives the ID stage
// and one skid entry that catches a fetch returning while ID is stalled.
module if_skid_buf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        push,
  input  logic [31:0] push_instr,
  input  logic [31:0] push_pc_next,
  input  logic        pop,
  input  logic        flush,
  output logic        valid,
  output logic        full,
  output logic [31:0] instruction,
  output logic [31:0] pc_next
);

  fetch_entry_t head_q;
  fetch_entry_t skid_q;
  fetch_entry_t in_entry;
  logic         head_valid_q;
  logic         skid_valid_q;

  assign in_entry = '{instruction: push_instr, pc_next: push_pc_next};

  // Head refills from the skid first so delivery order is preserved; a flush
  // drops both entries and parks the outputs at the NOP value.
  always_ff @(posedge clk) begin
    if (nrst || flush) begin
      head_q       <= '{instruction: INSTR_NOP, pc_next: 32'h0};
      head_valid_q <= 1'b0;
      skid_q       <= '{instruction: INSTR_NOP, pc_next: 32'h0};
      skid_valid_q <= 1'b0;
    end else if (!head_valid_q || pop) begin
      if (skid_valid_q) begin
        head_q       <= skid_q;
        head_valid_q <= 1'b1;
        skid_valid_q <= push;
        if (push) begin
          skid_q <= in_entry;
        end
      end else if (push) begin
        head_q       <= in_entry;
        head_valid_q <= 1'b1;
      end else begin
        head_valid_q <= 1'b0;
      end
    end else if (push) begin
      skid_q       <= in_entry;
      skid_valid_q <= 1'b1;
    end
  end

  assign valid       = head_valid_q;
  assign full        = skid_valid_q;
  assign instruction = head_q.instruction;
  assign pc_next     = head_q.pc_next;

endmodule

// File: rtl/if_fetch.sv
// MIPS instruction-fetch stage: owns the PC, requests instruction memory and
// hands {instruction, PC+4} to ID through a two-entry buffer.
//
// Handshakes:
//   memory side: Req is held high with a stable Addr until Ack; Ack may come
//                in the same cycle Req rises and is never given with Req=0.
//   ID side:     an item transfers in every cycle with Valid=1 and Stall=0;
//                while Stall=1 the o_ID_* outputs hold.
// A redirect (PCSrc) beats both Stall and Ack capture: all buffered work is
// flushed, and a request already in flight is completed and its data thrown
// away (DROP) before the target is fetched.
module if_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_IF_ctrl_PCSrc,
  input  logic [31:0] i_IF_data_PCBranch,
  input  logic        i_IF_ctrl_Stall,
  output logic        o_IF_mem_ImemReq,
  output logic [31:0] o_IF_mem_ImemAddr,
  input  logic        i_IF_mem_ImemAck,
  input  logic [31:0] i_IF_mem_ImemDataR,
  output logic        o_ID_ctrl_Valid,
  output logic [31:0] o_ID_data_instruction,
  output logic [31:0] o_ID_data_PCNext,
  output logic [1:0]  dbg_state
);

  fetch_state_t state_q;
  logic         req_q;
  logic [31:0]  pc_q;
  logic [31:0]  redir_q;
  logic [31:0]  pc_plus4;

  logic buf_valid;
  logic buf_full;
  logic pop;
  logic buf_free;
  logic capture;

  assign pc_plus4 = pc_q + 32'd4;
  assign pop      = buf_valid && !i_IF_ctrl_Stall;
  assign buf_free = !buf_valid || pop;
  // A returning fetch is kept only on the normal path with room in the skid.
  assign capture  = (state_q == FETCH) && i_IF_mem_ImemAck && !i_IF_ctrl_PCSrc && !buf_full;

  if_skid_buf u_buf (
    .clk          (clk),
    .nrst         (nrst),
    .push         (capture),
    .push_instr   (i_IF_mem_ImemDataR),
    .push_pc_next (pc_plus4),
    .pop          (pop),
    .flush        (i_IF_ctrl_PCSrc),
    .valid        (buf_valid),
    .full         (buf_full),
    .instruction  (o_ID_data_instruction),
    .pc_next      (o_ID_data_PCNext)
  );

  // Fetch FSM with PC, redirect target and a registered memory request.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      redir_q <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
          if (i_IF_ctrl_PCSrc) begin
            pc_q <= i_IF_data_PCBranch;
          end
        end
        FETCH: begin
          if (i_IF_ctrl_PCSrc) begin
            if (i_IF_mem_ImemAck) begin
              pc_q <= i_IF_data_PCBranch;
            end else begin
              redir_q <= i_IF_data_PCBranch;
              state_q <= DROP;
            end
          end else if (capture) begin
            pc_q <= pc_plus4;
            if (!buf_free) begin
              state_q <= WAIT_OUT;
              req_q   <= 1'b0;
            end
          end
        end
        WAIT_OUT: begin
          if (i_IF_ctrl_PCSrc) begin
            pc_q    <= i_IF_data_PCBranch;
            state_q <= FETCH;
            req_q   <= 1'b1;
          end else if (!i_IF_ctrl_Stall) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        DROP: begin
          if (i_IF_mem_ImemAck) begin
            pc_q    <= i_IF_ctrl_PCSrc ? i_IF_data_PCBranch : redir_q;
            state_q <= FETCH;
          end else if (i_IF_ctrl_PCSrc) begin
            redir_q <= i_IF_data_PCBranch;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_IF_mem_ImemReq  = req_q;
  assign o_IF_mem_ImemAddr = pc_q;
  assign o_ID_ctrl_Valid   = buf_valid;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios followed by randomized traffic, all
// checked against a transaction-level model (expected fetch address plus a
// queue of instructions still owed to ID).
module tb_if_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        nrst;
  logic        pcsrc;
  logic [31:0] pcbranch;
  logic        stall;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] datar;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pcnext;
  logic [1:0]  dbg;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pcnext;
  logic [1:0]  w_dbg;
  logic        w_ack;
  logic [31:0] w_datar;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk                   (clk),
    .nrst                  (nrst),
    .i_IF_ctrl_PCSrc       (pcsrc),
    .i_IF_data_PCBranch    (pcbranch),
    .i_IF_ctrl_Stall       (stall),
    .o_IF_mem_ImemReq      (req),
    .o_IF_mem_ImemAddr     (addr),
    .i_IF_mem_ImemAck      (ack),
    .i_IF_mem_ImemDataR    (datar),
    .o_ID_ctrl_Valid       (valid),
    .o_ID_data_instruction (instr),
    .o_ID_data_PCNext      (pcnext),
    .dbg_state             (dbg)
  );

  // Second instance: zero-wait memory starting just below the address wrap.
  assign w_ack   = w_req;
  assign w_datar = w_addr ^ KEY;

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk                   (clk),
    .nrst                  (nrst),
    .i_IF_ctrl_PCSrc       (1'b0),
    .i_IF_data_PCBranch    (32'h0),
    .i_IF_ctrl_Stall       (1'b0),
    .o_IF_mem_ImemReq      (w_req),
    .o_IF_mem_ImemAddr     (w_addr),
    .i_IF_mem_ImemAck      (w_ack),
    .i_IF_mem_ImemDataR    (w_datar),
    .o_ID_ctrl_Valid       (w_valid),
    .o_ID_data_instruction (w_instr),
    .o_ID_data_PCNext      (w_pcnext),
    .dbg_state             (w_dbg)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] m_pc;
  logic [31:0] m_target;
  bit          m_drop;
  logic [63:0] exp_q[$];
  int          checks;
  int          failures;
  int          delivered;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: check outputs, drive one cycle of inputs,
  // advance the model by that cycle, then move to the next falling edge.
  task automatic step(input logic s, input logic ps, input logic [31:0] br, input logic ak);
    logic ack_now;
    check("valid", 32'(valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("instr", instr, exp_q[0][63:32]);
      check("pcnext", pcnext, exp_q[0][31:0]);
    end
    check("addr", addr, m_pc);
    if (exp_q.size() >= 2) check("req_full", 32'(req), 32'd0);
    if (m_drop) check("req_drop", 32'(req), 32'd1);
    ack_now  = ak && req;
    stall    = s;
    pcsrc    = ps;
    pcbranch = br;
    ack      = ack_now;
    datar    = ack_now ? (addr ^ KEY) : $urandom;
    if (ps) begin
      exp_q.delete();
      if (req && !ack_now) begin
        m_drop   = 1'b1;
        m_target = br;
      end else begin
        m_drop = 1'b0;
        m_pc   = br;
      end
    end else begin
      if (exp_q.size() != 0 && !s) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (ack_now) begin
        if (m_drop) begin
          m_pc   = m_target;
          m_drop = 1'b0;
        end else begin
          exp_q.push_back({m_pc ^ KEY, m_pc + 32'd4});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset 3 cycles, check reset values, release and check Req timing.
  task automatic do_reset(input bit first);
    nrst     = 1'b1;
    stall    = 1'b0;
    pcsrc    = 1'b0;
    pcbranch = 32'h0;
    ack      = 1'b0;
    datar    = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(req), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_addr", addr, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pcnext", pcnext, 32'h0);
    nrst = 1'b0;
    exp_q.delete();
    m_pc   = 32'h0;
    m_drop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rel_req", 32'(req), 32'd1);
    check("rel_addr", addr, 32'h0);
    if (first) begin
      check("wrap_req", 32'(w_req), 32'd1);
      check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        r_s;
    logic        r_ps;
    logic [31:0] r_br;
    checks    = 0;
    failures  = 0;
    delivered = 0;
    nrst      = 1'b1;

    do_reset(1'b1);

    // zero-wait stream
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("s0_instr", instr, 32'hA5A5_0000);
    check("s0_pcnext", pcnext, 32'h4);
    check("wrap_pcnext", w_pcnext, 32'h0);
    check("wrap_instr", w_instr, 32'h5A5A_FFFC);
    check("wrap_addr1", w_addr, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("s1_instr", instr, 32'hA5A5_0004);
    check("s1_pcnext", pcnext, 32'h8);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("s2_instr", instr, 32'hA5A5_0008);
    check("s2_pcnext", pcnext, 32'hC);

    // stall for 3 cycles while the PC=8 instruction is on the outputs
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("st0_instr", instr, 32'hA5A5_0008);
    check("st0_req", 32'(req), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("st1_instr", instr, 32'hA5A5_0008);
    check("st1_req", 32'(req), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("st_skid_instr", instr, 32'hA5A5_000C);
    check("st_skid_pcnext", pcnext, 32'h10);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("st_next_pcnext", pcnext, 32'h14);

    // redirect while a request to 0x20 is outstanding
    for (int i = 0; i < 16 && m_pc != 32'h20; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    check("rd_addr0", addr, 32'h20);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h100, 1'b0);
    check("rd_hold1", addr, 32'h20);
    check("rd_valid1", 32'(valid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("rd_hold2", addr, 32'h20);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("rd_req_tgt", 32'(req), 32'd1);
    check("rd_addr_tgt", addr, 32'h100);
    check("rd_valid_tgt", 32'(valid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("rd_pcnext", pcnext, 32'h104);
    check("rd_instr", instr, 32'h100 ^ KEY);

    // redirect + ack + stall together with Valid=1
    check("sim_valid_pre", 32'(valid), 32'd1);
    step(1'b1, 1'b1, 32'h200, 1'b1);
    check("sim_valid", 32'(valid), 32'd0);
    check("sim_addr", addr, 32'h200);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("sim_pcnext0", pcnext, 32'h204);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("sim_pcnext1", pcnext, 32'h208);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r_s  = ($urandom_range(0, 3) == 0);
      r_ps = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       r_br = 32'hFFFF_FFF8;
        1:       r_br = $urandom;
        default: r_br = $urandom & 32'h0000_FFFC;
      endcase
      step(r_s, r_ps, r_br, ($urandom_range(0, 9) < 6));
    end

    // reset while a request is outstanding, then resume
    for (int i = 0; i < 16 && !req; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("mid_req_seen", 32'(req), 32'd1);
    do_reset(1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("mid_instr", instr, 32'hA5A5_0000);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("mid_pcnext", pcnext, 32'h8);

    check("progress", 32'(delivered > 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
